// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master_pkg: shared state encoding and protocol byte constants
// for the UART debug/loader bus bridge and its transmit sequencer.
package uart_bus_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        SEND,
        SEND_WAIT_HI,
        SEND_WAIT_LO
    } state_t;

    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_READ   = 8'h52;
    localparam logic [7:0] RSP_ACK    = 8'h2B;
    localparam logic [7:0] RSP_NAK    = 8'h3F;
    localparam logic [7:0] RSP_BUSERR = 8'h21;

endpackage

// File: rtl/uart_bus_master_tx_seq.sv
// uart_bus_master_tx_seq: sends 1..4 bytes of a word (LSB first) to a UART
// transmitter, one transmit pulse per byte, pacing on is_transmitting.
// Ports: clk, rst (sync, active-high); start/word/count load a response;
// is_transmitting from the UART; tx_byte/transmit to the UART; done pulses
// in the cycle the last byte has finished (sequencer returns to IDLE).
module uart_bus_master_tx_seq
    import uart_bus_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [2:0]  count,
    input  logic        is_transmitting,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    output logic        done
);

    state_t      state, state_nx;
    logic [31:0] shift, shift_nx;
    logic [2:0]  left, left_nx;
    logic [7:0]  byte_nx;
    logic        pulse_nx;

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        left_nx  = left;
        byte_nx  = tx_byte;
        pulse_nx = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SEND;
                    shift_nx = word;
                    left_nx  = count;
                end
            end
            SEND: begin
                if (!is_transmitting) begin
                    byte_nx  = shift[7:0];
                    pulse_nx = 1'b1;
                    shift_nx = {8'h00, shift[31:8]};
                    left_nx  = left - 3'd1;
                    state_nx = SEND_WAIT_HI;
                end
            end
            SEND_WAIT_HI: begin
                if (is_transmitting) begin
                    state_nx = SEND_WAIT_LO;
                end
            end
            SEND_WAIT_LO: begin
                if (!is_transmitting) begin
                    if (left != 3'd0) begin
                        state_nx = SEND;
                    end else begin
                        state_nx = IDLE;
                        done     = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= 32'h0;
            left     <= 3'd0;
            tx_byte  <= 8'h00;
            transmit <= 1'b0;
        end else begin
            state    <= state_nx;
            shift    <= shift_nx;
            left     <= left_nx;
            tx_byte  <= byte_nx;
            transmit <= pulse_nx;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command decoder driving the valid/ready memory bus.
// Ports: clk, rst (sync, active-high); rx_byte/received from UART RX;
// tx_byte/transmit/is_transmitting to UART TX; mem_* bus initiator side;
// active is high while a command is in progress (CPU hold-off).
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int SYS_CLK_FREQ       = 50_000_000,
    parameter int RX_TIMEOUT_CYCLES  = 5_000_000,
    parameter int BUS_TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        received,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        is_transmitting,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        active
);

    localparam int RXW = $clog2(RX_TIMEOUT_CYCLES + 1);
    localparam int BTW = $clog2(BUS_TIMEOUT_CYCLES + 1);

    state_t         state, state_nx;
    logic           is_write, is_write_nx;
    logic [1:0]     byte_cnt, byte_cnt_nx;
    logic [RXW-1:0] rx_timer, rx_timer_nx;
    logic [BTW-1:0] bus_timer, bus_timer_nx;
    logic [31:0]    addr_nx, wdata_nx;
    logic           valid_nx;
    logic [3:0]     wstrb_nx;

    logic           tx_start;
    logic [31:0]    tx_word;
    logic [2:0]     tx_count;
    logic           tx_done;

    always_comb begin
        state_nx     = state;
        is_write_nx  = is_write;
        byte_cnt_nx  = byte_cnt;
        rx_timer_nx  = rx_timer;
        bus_timer_nx = bus_timer;
        addr_nx      = mem_addr;
        wdata_nx     = mem_wdata;
        valid_nx     = mem_valid;
        wstrb_nx     = mem_wstrb;
        tx_start     = 1'b0;
        tx_word      = {24'h0, RSP_NAK};
        tx_count     = 3'd1;
        case (state)
            IDLE: begin
                if (received) begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                        state_nx    = GET_ADDR;
                        is_write_nx = (rx_byte == CMD_WRITE);
                        byte_cnt_nx = 2'd0;
                        rx_timer_nx = '0;
                    end else begin
                        state_nx = SEND;
                        tx_start = 1'b1;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                // A byte arriving on the expiry cycle still counts.
                if (received) begin
                    rx_timer_nx = '0;
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (state == GET_ADDR) begin
                        addr_nx[{byte_cnt, 3'b000} +: 8] = rx_byte;
                        addr_nx[1:0] = 2'b00;
                    end else begin
                        wdata_nx[{byte_cnt, 3'b000} +: 8] = rx_byte;
                    end
                    if (byte_cnt == 2'd3) begin
                        if (state == GET_ADDR && is_write) begin
                            state_nx = GET_DATA;
                        end else begin
                            state_nx     = BUS;
                            valid_nx     = 1'b1;
                            wstrb_nx     = is_write ? 4'hF : 4'h0;
                            bus_timer_nx = '0;
                        end
                    end
                end else if (rx_timer == RXW'(RX_TIMEOUT_CYCLES)) begin
                    state_nx = IDLE;
                end else begin
                    rx_timer_nx = rx_timer + 1'b1;
                end
            end
            BUS: begin
                bus_timer_nx = bus_timer + 1'b1;
                if (mem_ready) begin
                    valid_nx = 1'b0;
                    wstrb_nx = 4'h0;
                    state_nx = SEND;
                    tx_start = 1'b1;
                    if (is_write) begin
                        tx_word = {24'h0, RSP_ACK};
                    end else begin
                        tx_word  = mem_rdata;
                        tx_count = 3'd4;
                    end
                end else if (bus_timer == BTW'(BUS_TIMEOUT_CYCLES - 1)) begin
                    valid_nx = 1'b0;
                    wstrb_nx = 4'h0;
                    state_nx = SEND;
                    tx_start = 1'b1;
                    tx_word  = {24'h0, RSP_BUSERR};
                end
            end
            SEND: begin
                if (tx_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            rx_timer  <= '0;
            bus_timer <= '0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
        end else begin
            state     <= state_nx;
            is_write  <= is_write_nx;
            byte_cnt  <= byte_cnt_nx;
            rx_timer  <= rx_timer_nx;
            bus_timer <= bus_timer_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mem_valid <= valid_nx;
            mem_wstrb <= wstrb_nx;
        end
    end

    assign active = (state != IDLE);

    uart_bus_master_tx_seq u_tx_seq (
        .clk             (clk),
        .rst             (rst),
        .start           (tx_start),
        .word            (tx_word),
        .count           (tx_count),
        .is_transmitting (is_transmitting),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .done            (tx_done)
    );

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed bench for uart_bus_master with a simple
// UART transmitter model and a delay-programmable memory responder.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        received = 1'b0;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        active;

    uart_bus_master #(
        .SYS_CLK_FREQ       (50_000_000),
        .RX_TIMEOUT_CYCLES  (100),
        .BUS_TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_byte         (rx_byte),
        .received        (received),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .active          (active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          ready_delay = -1;
    logic [31:0] rdata_val = 32'h0;
    logic        late_req = 1'b0;

    int          n_rise = 0;
    int          n_vcyc = 0;
    int          width_err = 0;
    int          overlap_err = 0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;
    logic [7:0]  txq[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte  = b;
        received = 1'b1;
        @(posedge clk);
        #1;
        received = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (!active) break;
            tick();
        end
        check(tag, {31'h0, active}, 32'h0);
    endtask

    // UART transmitter model: busy shortly after each transmit pulse.
    initial begin
        forever begin
            tick();
            if (transmit) begin
                repeat (2) @(posedge clk);
                #1 is_transmitting = 1'b1;
                repeat (6) @(posedge clk);
                #1 is_transmitting = 1'b0;
            end
        end
    end

    // Memory responder: ready on the ready_delay-th cycle of mem_valid.
    initial begin
        int rcnt;
        rcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            tick();
            if (mem_valid) rcnt++;
            else rcnt = 0;
            mem_ready = late_req ||
                        (mem_valid && ready_delay > 0 && rcnt == ready_delay);
            mem_rdata = mem_ready ? rdata_val : 32'h0;
        end
    end

    // Observer on the falling edge, away from DUT and model updates.
    initial begin
        logic pv, pt;
        pv = 1'b0;
        pt = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_valid && !pv) begin
                n_rise++;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
            end
            if (mem_valid) n_vcyc++;
            if (transmit) begin
                txq.push_back(tx_byte);
                if (pt) width_err++;
                if (is_transmitting) overlap_err++;
            end
            pv = mem_valid;
            pt = transmit;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, v0, t0;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
        check("rst_transmit", {31'h0, transmit}, 32'h0);
        check("rst_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_active", {31'h0, active}, 32'h0);

        // Write 0xDEADBEEF to 0x40000100, ready on 3rd cycle.
        ready_delay = 3;
        r0 = n_rise; v0 = n_vcyc; t0 = txq.size();
        send_byte(8'h57);
        check("wr_active", {31'h0, active}, 32'h1);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h40);
        send_byte(8'hEF); send_byte(8'hBE);
        send_byte(8'hAD); send_byte(8'hDE);
        check("wr_latency", {31'h0, mem_valid}, 32'h1);
        wait_idle("wr_idle");
        check("wr_rises", n_rise - r0, 1);
        check("wr_vcyc", n_vcyc - v0, 3);
        check("wr_addr", cap_addr, 32'h4000_0100);
        check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("wr_wstrb", {28'h0, cap_wstrb}, 32'hF);
        check("wr_ntx", txq.size() - t0, 1);
        if (txq.size() > t0) check("wr_tx0", {24'h0, txq[t0]}, 32'h2B);

        // Read from 0x07 (aligned to 0x04), data 0x12345678.
        ready_delay = 2;
        rdata_val = 32'h1234_5678;
        r0 = n_rise; v0 = n_vcyc; t0 = txq.size();
        send_byte(8'h52); send_byte(8'h07);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("rd_latency", {31'h0, mem_valid}, 32'h1);
        wait_idle("rd_idle");
        check("rd_rises", n_rise - r0, 1);
        check("rd_vcyc", n_vcyc - v0, 2);
        check("rd_addr", cap_addr, 32'h0000_0004);
        check("rd_wstrb", {28'h0, cap_wstrb}, 32'h0);
        check("rd_ntx", txq.size() - t0, 4);
        if (txq.size() >= t0 + 4) begin
            check("rd_tx0", {24'h0, txq[t0]}, 32'h78);
            check("rd_tx1", {24'h0, txq[t0+1]}, 32'h56);
            check("rd_tx2", {24'h0, txq[t0+2]}, 32'h34);
            check("rd_tx3", {24'h0, txq[t0+3]}, 32'h12);
        end

        // Unknown command byte.
        r0 = n_rise; t0 = txq.size();
        send_byte(8'h41);
        check("bad_active", {31'h0, active}, 32'h1);
        wait_idle("bad_idle");
        check("bad_rises", n_rise - r0, 0);
        check("bad_ntx", txq.size() - t0, 1);
        if (txq.size() > t0) check("bad_tx0", {24'h0, txq[t0]}, 32'h3F);

        // Partial command then silence.
        r0 = n_rise; t0 = txq.size();
        send_byte(8'h52); send_byte(8'h00);
        repeat (50) tick();
        check("rxto_mid", {31'h0, active}, 32'h1);
        repeat (60) tick();
        check("rxto_idle", {31'h0, active}, 32'h0);
        check("rxto_rises", n_rise - r0, 0);
        check("rxto_ntx", txq.size() - t0, 0);

        ready_delay = 1;
        rdata_val = 32'hA5A5_0F0F;
        t0 = txq.size();
        send_byte(8'h52); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_idle("rxto_rd_idle");
        check("rxto_rd_addr", cap_addr, 32'h0000_0010);
        check("rxto_rd_ntx", txq.size() - t0, 4);
        if (txq.size() >= t0 + 4) begin
            check("rxto_rd_tx0", {24'h0, txq[t0]}, 32'h0F);
            check("rxto_rd_tx3", {24'h0, txq[t0+3]}, 32'hA5);
        end

        // Bus timeout on a read of 0xF0002000.
        ready_delay = -1;
        r0 = n_rise; v0 = n_vcyc; t0 = txq.size();
        send_byte(8'h52); send_byte(8'h00);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'hF0);
        wait_idle("bto_idle");
        check("bto_rises", n_rise - r0, 1);
        check("bto_vcyc", n_vcyc - v0, 16);
        check("bto_addr", cap_addr, 32'hF000_2000);
        check("bto_ntx", txq.size() - t0, 1);
        if (txq.size() > t0) check("bto_tx0", {24'h0, txq[t0]}, 32'h21);

        // Reset while the bus request is outstanding.
        r0 = n_rise; t0 = txq.size();
        send_byte(8'h52); send_byte(8'h08);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (3) tick();
        check("mrst_pre_valid", {31'h0, mem_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", {31'h0, mem_valid}, 32'h0);
        check("mrst_active", {31'h0, active}, 32'h0);
        check("mrst_addr", mem_addr, 32'h0);
        check("mrst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("mrst_transmit", {31'h0, transmit}, 32'h0);
        late_req = 1'b1;
        repeat (2) tick();
        late_req = 1'b0;
        repeat (30) tick();
        check("mrst_late_valid", {31'h0, mem_valid}, 32'h0);
        check("mrst_late_active", {31'h0, active}, 32'h0);
        check("mrst_rises", n_rise - r0, 1);
        check("mrst_ntx", txq.size() - t0, 0);

        check("tx_width_err", width_err, 0);
        check("tx_overlap_err", overlap_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
